// File: rtl/bdm_session_ctrl_if.sv
// rtl/bdm_session_ctrl_if.sv - Signal bundle between the BDM session sequencer and its host, startup controller, command engine and BKGD pin.
interface bdm_session_ctrl_if;
  logic        pwr_req;
  logic        resync_req;
  logic        su_start;
  logic        su_stop;
  logic        su_ready;
  logic        su_is_sending;
  logic        bkgd_in;
  logic        cmd_bkgd_oe;
  logic        bkgd_oe;
  logic        cmd_en;
  logic        session_up;
  logic [15:0] sync_period;
  logic        err_timeout;

  modport slave (
    input  pwr_req, resync_req, su_ready, su_is_sending, bkgd_in, cmd_bkgd_oe,
    output su_start, su_stop, bkgd_oe, cmd_en, session_up, sync_period, err_timeout
  );

  modport master (
    output pwr_req, resync_req, su_ready, su_is_sending, bkgd_in, cmd_bkgd_oe,
    input  su_start, su_stop, bkgd_oe, cmd_en, session_up, sync_period, err_timeout
  );
endinterface

// File: rtl/bdm_session_ctrl.sv
// rtl/bdm_session_ctrl.sv - BDM session sequencer: target power-up, SYNC bit-period measurement, teardown.
// Optional BDM_SYNC_AVG_EN: four SYNC passes are averaged into sync_period.
module bdm_session_ctrl #(
  parameter int SYNC_LOW_CYCLES = 6400,
  parameter int SYNC_TIMEOUT    = 50000
) (
  input  logic              clk,
  input  logic              rst,
  bdm_session_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, START, ARM, WAIT_PWR, SYNC_LOW, SYNC_WAIT_FALL, SYNC_MEASURE, UP, ERROR
  } state_t;

  typedef enum logic [1:0] {OE_OFF, OE_LOW, OE_SU, OE_CMD} oe_sel_t;

  localparam logic [15:0] LOW_LAST = 16'(SYNC_LOW_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(SYNC_TIMEOUT - 1);

  state_t      state_q, state_d;
  oe_sel_t     oe_sel_q, oe_sel_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] period_q, period_d;
  logic        su_start_q, su_start_d;
  logic        su_stop_q, su_stop_d;
  logic        up_q, up_d;
  logic        err_q, err_d;
  logic        bkgd_meta_q, bkgd_sync_q, bkgd_prev_q;
  logic        bkgd_fall, bkgd_rise, timed_out, oe_mux;
`ifdef BDM_SYNC_AVG_EN
  logic [1:0]  pass_q, pass_d;
  logic [17:0] acc_q, acc_d, sum;
`endif

  assign bkgd_fall = bkgd_prev_q & ~bkgd_sync_q;
  assign bkgd_rise = ~bkgd_prev_q & bkgd_sync_q;
  assign timed_out = (timer_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
`ifdef BDM_SYNC_AVG_EN
    pass_d   = pass_q;
    acc_d    = acc_q;
    sum      = acc_q + {2'b00, cnt_q};
`endif
    case (state_q)
      IDLE:     if (bus.pwr_req) state_d = START;
      START:    state_d = ARM;
      // su_ready is still high from the previous session during START
      ARM:      state_d = WAIT_PWR;
      WAIT_PWR: begin
        if (bus.su_ready) begin
          state_d = SYNC_LOW;
`ifdef BDM_SYNC_AVG_EN
          pass_d  = '0;
          acc_d   = '0;
`endif
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      SYNC_LOW: if (timer_q == LOW_LAST) state_d = SYNC_WAIT_FALL;
      SYNC_WAIT_FALL: begin
        if (bkgd_fall) begin
          state_d = SYNC_MEASURE;
          cnt_d   = 16'd1;
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      SYNC_MEASURE: begin
        if (bkgd_rise) begin
`ifdef BDM_SYNC_AVG_EN
          if (pass_q == 2'd3) begin
            period_d = sum[17:2];
            state_d  = UP;
          end else begin
            acc_d   = sum;
            pass_d  = pass_q + 2'd1;
            state_d = SYNC_LOW;
          end
`else
          period_d = cnt_q;
          state_d  = UP;
`endif
        end else if (cnt_q == 16'hFFFF || timed_out) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      UP: begin
        if (bus.resync_req) begin
          state_d = SYNC_LOW;
`ifdef BDM_SYNC_AVG_EN
          pass_d  = '0;
          acc_d   = '0;
`endif
        end
      end
      ERROR:    state_d = ERROR;
      default:  state_d = IDLE;
    endcase

    // Power-down wins over every other event in the same cycle
    if (state_q != IDLE && !bus.pwr_req) begin
      state_d  = IDLE;
      period_d = '0;
    end

    timer_d    = (state_d != state_q) ? '0 : timer_q + 16'd1;
    su_start_d = (state_d == START);
    su_stop_d  = (state_d == IDLE) || (state_d == ERROR);
    up_d       = (state_d == UP);
    err_d      = (state_d == ERROR);
    case (state_d)
      WAIT_PWR: oe_sel_d = OE_SU;
      SYNC_LOW: oe_sel_d = OE_LOW;
      UP:       oe_sel_d = OE_CMD;
      default:  oe_sel_d = OE_OFF;
    endcase
  end

  always_comb begin
    oe_mux = 1'b0;
    case (oe_sel_q)
      OE_LOW:  oe_mux = 1'b1;
      OE_SU:   oe_mux = bus.su_is_sending;
      OE_CMD:  oe_mux = bus.cmd_bkgd_oe;
      default: oe_mux = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      oe_sel_q    <= OE_OFF;
      timer_q     <= '0;
      cnt_q       <= '0;
      period_q    <= '0;
      su_start_q  <= 1'b0;
      su_stop_q   <= 1'b1;
      up_q        <= 1'b0;
      err_q       <= 1'b0;
      bkgd_meta_q <= 1'b1;
      bkgd_sync_q <= 1'b1;
      bkgd_prev_q <= 1'b1;
`ifdef BDM_SYNC_AVG_EN
      pass_q      <= '0;
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      oe_sel_q    <= oe_sel_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      su_start_q  <= su_start_d;
      su_stop_q   <= su_stop_d;
      up_q        <= up_d;
      err_q       <= err_d;
      bkgd_meta_q <= bus.bkgd_in;
      bkgd_sync_q <= bkgd_meta_q;
      bkgd_prev_q <= bkgd_sync_q;
`ifdef BDM_SYNC_AVG_EN
      pass_q      <= pass_d;
      acc_q       <= acc_d;
`endif
    end
  end

  assign bus.su_start    = su_start_q;
  assign bus.su_stop     = su_stop_q;
  assign bus.cmd_en      = up_q;
  assign bus.session_up  = up_q;
  assign bus.sync_period = period_q;
  assign bus.err_timeout = err_q;
  assign bus.bkgd_oe     = bus.pwr_req & oe_mux;
endmodule

// File: tb/tb_bdm_session_ctrl.sv
// tb/tb_bdm_session_ctrl.sv - Scoreboard bench for bdm_session_ctrl with startup-controller and target models.
module tb_bdm_session_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic tgt_low;
  int   su_delay;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   su_start_cnt = 0;
  int   sync_cnt = 0;
  int   last_run = 0;
  int   oe_run = 0;
  int   oe_fall_cyc = 0;
  int   rsp_run = 0;
  int   rsp_w;
  logic up_prev = 1'b0;
  logic err_prev = 1'b0;
  int   exp_period_q[$];
  int   exp_gap_q[$];
  int   resp_q[$];

  bdm_session_ctrl_if bif();

  bdm_session_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  // Open-drain BKGD line: low if either side pulls it
  assign bif.bkgd_in = !(bif.bkgd_oe || tgt_low);

  task automatic check(input string name, input int act, input int exp_v, input int tol = 0);
    total++;
    if (act > exp_v + tol || act < exp_v - tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic logic sig_val(input int sel);
    case (sel)
      0:       return bif.session_up;
      1:       return bif.err_timeout;
      default: return tgt_low;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (sig_val(sel) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(sig_val(sel)), int'(val));
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_su_start"}, bif.su_start, 0);
    check({pfx, "_su_stop"}, bif.su_stop, 1);
    check({pfx, "_bkgd_oe"}, bif.bkgd_oe, 0);
    check({pfx, "_cmd_en"}, bif.cmd_en, 0);
    check({pfx, "_session_up"}, bif.session_up, 0);
    check({pfx, "_sync_period"}, bif.sync_period, 0);
    check({pfx, "_err_timeout"}, bif.err_timeout, 0);
  endtask

  task automatic pulse_resync();
    @(posedge clk);
    #1 bif.resync_req = 1'b1;
    @(posedge clk);
    #1 bif.resync_req = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a captured period or a timeout
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bif.su_start) su_start_cnt++;
      if (bif.bkgd_oe) begin
        oe_run++;
      end else begin
        if (oe_run > 0) begin
          last_run = oe_run;
          if (oe_run >= 6000) begin
            sync_cnt++;
            oe_fall_cyc = cyc;
          end
        end
        oe_run = 0;
      end
      if (bif.session_up && !up_prev) begin
        if (exp_period_q.size() == 0) check("unexpected_session_up", 1, 0);
        else check("sb_sync_period", bif.sync_period, exp_period_q.pop_front(), 1);
      end
      if (bif.err_timeout && !err_prev) begin
        if (exp_gap_q.size() == 0) check("unexpected_err_timeout", 1, 0);
        else check("sb_timeout_gap", cyc - oe_fall_cyc, exp_gap_q.pop_front());
      end
      up_prev  = bif.session_up;
      err_prev = bif.err_timeout;
    end
  end

  // Startup controller: ready drops on su_start and returns after su_delay cycles
  initial begin
    bif.su_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bif.su_start) begin
        bif.su_ready = 1'b0;
        repeat (su_delay) @(negedge clk);
        bif.su_ready = 1'b1;
      end
    end
  end

  // Target: after each host SYNC low, wait 16 cycles then pull BKGD low for the queued width
  initial begin
    tgt_low = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.bkgd_oe) begin
        rsp_run++;
      end else begin
        if (rsp_run >= 6000 && resp_q.size() > 0) begin
          rsp_w = resp_q.pop_front();
          repeat (16) @(negedge clk);
          tgt_low = 1'b1;
          repeat (rsp_w) @(negedge clk);
          tgt_low = 1'b0;
        end
        rsp_run = 0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    bif.pwr_req = 1'b0;
    bif.resync_req = 1'b0;
    bif.su_is_sending = 1'b0;
    bif.cmd_bkgd_oe = 1'b0;
    su_delay = 20;
    repeat (3) @(negedge clk);
    check_reset("rst");
    @(posedge clk);
    #1 rst = 1'b0;

`ifndef BDM_SYNC_AVG_EN
    su_delay = 1953;
    su_start_cnt = 0;
    resp_q.push_back(2048);
    exp_period_q.push_back(2048);
    bif.pwr_req = 1'b1;
    wait_for(0, 1'b1, 20000, "nominal_up");
    check("nominal_cmd_en", bif.cmd_en, 1);
    check("nominal_su_start_pulses", su_start_cnt, 1);
    check("nominal_sync_low_len", last_run, 6400);
    check("nominal_su_stop", bif.su_stop, 0);

    @(posedge clk);
    #2 bif.cmd_bkgd_oe = 1'b1;
    #1 check("pass_cmd_oe_hi", bif.bkgd_oe, 1);
    bif.cmd_bkgd_oe = 1'b0;
    bif.su_is_sending = 1'b1;
    #1 check("pass_cmd_oe_lo", bif.bkgd_oe, 0);
    bif.su_is_sending = 1'b0;

    resp_q.push_back(1024);
    exp_period_q.push_back(1024);
    pulse_resync();
    @(negedge clk);
    check("resync_cmd_en_drop", bif.cmd_en, 0);
    check("resync_up_drop", bif.session_up, 0);
    check("resync_period_hold", bif.sync_period, 2048, 1);
    wait_for(0, 1'b1, 12000, "resync_up");
    check("resync_cmd_en", bif.cmd_en, 1);
    check("resync_period", bif.sync_period, 1024, 1);

    resp_q.push_back(1500);
    pulse_resync();
    wait_for(2, 1'b1, 8000, "drop_tgt_low");
    repeat (100) @(negedge clk);
    @(posedge clk);
    #1 bif.pwr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("drop_bkgd_oe", bif.bkgd_oe, 0);
    check("drop_su_stop", bif.su_stop, 1);
    check("drop_sync_period", bif.sync_period, 0);
    check("drop_cmd_en", bif.cmd_en, 0);
    wait_for(2, 1'b0, 3000, "drop_tgt_release");

    su_delay = 20;
    exp_gap_q.push_back(50000);
    @(posedge clk);
    #1 bif.pwr_req = 1'b1;
    wait_for(1, 1'b1, 60000, "tmo_err");
    check("tmo_su_stop", bif.su_stop, 1);
    check("tmo_cmd_en", bif.cmd_en, 0);
    check("tmo_session_up", bif.session_up, 0);
    @(posedge clk);
    #1 bif.pwr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("tmo_err_clear", bif.err_timeout, 0);
    check("tmo_idle_su_stop", bif.su_stop, 1);
`else
    su_delay = 20;
    sync_cnt = 0;
    resp_q.push_back(100);
    resp_q.push_back(102);
    resp_q.push_back(98);
    resp_q.push_back(101);
    exp_period_q.push_back(100);
    @(posedge clk);
    #1 bif.pwr_req = 1'b1;
    wait_for(0, 1'b1, 40000, "avg_up");
    check("avg_sync_phases", sync_cnt, 4);
    check("avg_cmd_en", bif.cmd_en, 1);
    check("avg_period", bif.sync_period, 100, 1);
    @(posedge clk);
    #1 bif.pwr_req = 1'b0;
    repeat (3) @(negedge clk);
    check("avg_drop_period", bif.sync_period, 0);
`endif

    su_delay = 1953;
    bif.su_is_sending = 1'b1;
    @(posedge clk);
    #1 bif.pwr_req = 1'b1;
    repeat (50) @(negedge clk);
    check("wait_pwr_su_stop", bif.su_stop, 0);
    check("wait_pwr_oe_pass", bif.bkgd_oe, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset("midrst");
    bif.pwr_req = 1'b0;
    bif.su_is_sending = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    repeat (5) @(negedge clk);
    check("sb_period_drained", exp_period_q.size(), 0);
    check("sb_gap_drained", exp_gap_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bdm_session_ctrl.md
# bdm_session_ctrl

Session-level sequencer for the BDM pod. Owns the power-up/sync/teardown sequence of one target MCU:
- drives the startup controller's start/stop;
- performs the BDM SYNC handshake to measure the target's bit period;
- hands the BKGD pin to the command engine only when the session is up.

It sits between the host command layer and the startup controller and command engine.

## Interface
Parameters:
- SYNC_LOW_CYCLES, 6400: clk cycles the host holds BKGD low for SYNC (128 µs at 50 MHz)
- SYNC_TIMEOUT, 50000: max clk cycles waited in any waiting state (1 ms)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- pwr_req  in  1  level; 1 = session requested, 0 = power target down
- resync_req  in  1  one-cycle pulse; re-measure the bit period while up
- su_start  out  1  one-cycle start pulse to startup controller
- su_stop  out  1  level stop to startup controller
- su_ready  in  1  startup controller ready
- su_is_sending  in  1  startup controller wants BKGD driven low
- bkgd_in  in  1  raw BKGD pin (asynchronous)
- cmd_bkgd_oe  in  1  command engine BKGD drive-low request
- bkgd_oe  out  1  drive BKGD low
- cmd_en  out  1  command engine may run
- session_up  out  1  sync complete, period valid
- sync_period  out  16  measured target SYNC-low width, clk cycles
- err_timeout  out  1  sticky error flag

## Operation
- bkgd_in passes through a 2-flop synchronizer. Edge detect is on the synchronized value.
- FSM states are IDLE, START, ARM, WAIT_PWR, SYNC_LOW, SYNC_WAIT_FALL, SYNC_MEASURE, UP and ERROR.
- IDLE:
  - su_stop=1, bkgd_oe=0.
  - pwr_req=1 -> START.
- START: su_start=1 for this one cycle -> ARM.
- ARM: exists because su_ready is still 1 during the start cycle. Lasts one cycle -> WAIT_PWR.
- WAIT_PWR:
  - bkgd_oe=su_is_sending.
  - su_ready=1 -> SYNC_LOW.
- SYNC_LOW:
  - bkgd_oe=1 for exactly SYNC_LOW_CYCLES cycles.
  - Then -> SYNC_WAIT_FALL.
- SYNC_WAIT_FALL:
  - bkgd_oe=0.
  - Falling edge of synchronized BKGD -> SYNC_MEASURE with counter=1.
- SYNC_MEASURE:
  - Counter increments each cycle BKGD stays low.
  - On the rising edge, the counter is loaded into sync_period -> UP.
- UP:
  - cmd_en=1, session_up=1, bkgd_oe=cmd_bkgd_oe.
  - resync_req -> SYNC_LOW.
- ERROR:
  - err_timeout=1, su_stop=1, bkgd_oe=0.
  - Leaves only on pwr_req=0 -> IDLE, which clears err_timeout.
- Watchdog:
  - A 16-bit timer reloads on every state entry.
  - In WAIT_PWR, SYNC_WAIT_FALL or SYNC_MEASURE, reaching SYNC_TIMEOUT -> ERROR.
- Measure counter saturation: the counter saturates at 0xFFFF; saturation -> ERROR.
- pwr_req=0 in any non-IDLE state:
  - -> IDLE next cycle.
  - session_up, cmd_en and bkgd_oe drop that cycle.
  - sync_period is cleared to 0.
  - pwr_req takes priority over resync_req and over a same-cycle edge or timeout.
- Reset values: IDLE; su_start=0, su_stop=1, bkgd_oe=0, cmd_en=0, session_up=0, sync_period=0, err_timeout=0.

## Timing
- Outputs are registered except bkgd_oe, which is a registered select muxed combinationally with su_is_sending or cmd_bkgd_oe (zero-cycle pass-through).
- Edge detection lags the pin by 2–3 cycles. Both edges lag equally, so the measured width is exact to ±1 cycle.
- cmd_en rises on the cycle after the rising edge is detected.
- resync_req in UP: cmd_en and session_up fall the next cycle; sync_period holds its old value until the new capture.
- resync_req outside UP is ignored.
- Asynchronous reset mid-operation forces IDLE and reset values immediately; su_stop=1 powers the target down.

## Configuration
- BDM_SYNC_AVG_EN defined:
  - SYNC_LOW..SYNC_MEASURE repeats 4 times in total.
  - An 18-bit accumulator sums the widths.
  - sync_period = sum>>2, truncated.
  - Any timeout or saturation in any pass -> ERROR.
  - UP is entered only after the 4th pass.
- Not defined: single measurement, sync_period = that width.

## Test plan
- Power-up, nominal:
  - Stimulus: pwr_req=1; model su_ready low for 1953 cycles after su_start; target drives BKGD low 2048 cycles, 16 cycles after release.
  - Required: su_start pulses exactly once; bkgd_oe high for 6400 cycles in SYNC_LOW; sync_period=2048±1; session_up=1; cmd_en=1.
- No target response:
  - Stimulus: BKGD held high after SYNC.
  - Required: err_timeout=1 exactly 50000 cycles after SYNC_LOW ends; su_stop=1; cmd_en=0.
  - Follow-up: pwr_req=0 clears err_timeout within 1 cycle.
- Drop mid-measure:
  - Stimulus: pwr_req=0 during SYNC_MEASURE.
  - Required: next cycle in IDLE; bkgd_oe=0; su_stop=1; sync_period=0.
- Resync:
  - Stimulus: in UP with period 2048, pulse resync_req; target answers 1024.
  - Required: cmd_en=0 next cycle; sync_period=1024 after capture; cmd_en=1 again.
- Reset mid-operation and pass-through:
  - Stimulus: assert rst during WAIT_PWR.
  - Required: all outputs take reset values without a clock edge.
  - Also: in UP, toggling cmd_bkgd_oe appears on bkgd_oe the same cycle.
- Averaging build:
  - Stimulus: BDM_SYNC_AVG_EN defined; widths 100, 102, 98, 101.
  - Required: sync_period=100; exactly 4 SYNC_LOW phases observed.
